mul_radix2: RTL and testbench

Sequential radix-2 shift-add multiplier for the EX stage, the multiply-side counterpart of the radix-2 divider. It serves MULT/MULTU: a 32×32 → 64-bit signed or unsigned product written to HI/LO. Operands are latched at issue so forwarding changes during the operation have no effect. The block raises a stall while busy, pulses `ready` when the product is valid, and aborts on `flush`.

---
 rtl/mul_radix2.sv | 104 ++++++++++
 tb/tb_mul_radix2.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mul_radix2.sv
`default_nettype none
// ============================================================================
// Module   : mul_radix2
// Brief    : Sequential radix-2 shift-add 32x32->64 multiplier (MULT/MULTU).
// Revision : 1.0 - initial release
// ============================================================================
module mul_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        valid,
  input  logic        sign,
  output logic        ready,
  output logic [63:0] result,
  output logic        mul_stall
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [5:0] c_LAST_CNT = 6'd32;

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_cnt;
  logic [63:0] r_p;
  logic [31:0] r_b;
  logic        r_neg;
  logic        r_ready;
  logic [63:0] r_result;

  logic        w_load;
  logic        w_done;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [32:0] w_sum;
  logic [63:0] w_p_next;

  // Magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign w_a_abs  = (sign & a[31]) ? (~a + 32'd1) : a;
  assign w_b_abs  = (sign & b[31]) ? (~b + 32'd1) : b;

  assign w_sum    = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_b} : 33'd0);
  assign w_p_next = {w_sum, r_p[31:1]};

  // No load while ready is high so a still-asserted valid is not re-issued.
  assign w_load   = (r_state == IDLE) & valid & ~r_ready;
  assign w_done   = (r_state == RUN) & (r_cnt == c_LAST_CNT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_load) w_state_next = RUN;
      RUN:     if (w_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) r_state <= IDLE;
    else              r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 6'd0;
      r_p      <= 64'd0;
      r_b      <= 32'd0;
      r_neg    <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= 64'd0;
    end else if (flush) begin
      r_cnt    <= 6'd0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (w_load) begin
        r_neg <= sign & (a[31] ^ b[31]);
        r_p   <= {32'd0, w_a_abs};
        r_b   <= w_b_abs;
        r_cnt <= 6'd1;
      end else if (r_state == RUN) begin
        r_p <= w_p_next;
        if (w_done) begin
          r_result <= r_neg ? (~w_p_next + 64'd1) : w_p_next;
          r_ready  <= 1'b1;
          r_cnt    <= 6'd0;
        end else begin
          r_cnt <= r_cnt + 6'd1;
        end
      end
    end
  end

  assign ready     = r_ready;
  assign result    = r_result;
  assign mul_stall = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_mul_radix2.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_radix2
// Brief    : Self-checking bench for mul_radix2 against a latency/product model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_radix2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        valid = 1'b0;
  logic        sign = 1'b0;
  logic        ready;
  logic [63:0] result;
  logic        mul_stall;

  int checks = 0;
  int passes = 0;

  mul_radix2 dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .a        (a),
    .b        (b),
    .valid    (valid),
    .sign     (sign),
    .ready    (ready),
    .result   (result),
    .mul_stall(mul_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    logic [63:0] ux, uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else passes++;
  endtask

  // Model: busy for 32 edges after the load edge, then one ready cycle.
  bit          m_live = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_ready = 1'b0;
  int          m_left = 0;
  logic [63:0] m_pend = 64'd0;
  logic [63:0] m_result = 64'd0;

  always @(posedge clk) begin
    m_live = 1'b1;
    if (rst) begin
      m_busy = 1'b0; m_ready = 1'b0; m_result = 64'd0;
    end else if (flush) begin
      m_busy = 1'b0; m_ready = 1'b0;
    end else if (m_busy) begin
      m_left--;
      m_ready = 1'b0;
      if (m_left == 0) begin
        m_busy = 1'b0; m_ready = 1'b1; m_result = m_pend;
      end
    end else if (valid && !m_ready) begin
      m_busy = 1'b1; m_left = 32; m_pend = prod(a, b, sign); m_ready = 1'b0;
    end else begin
      m_ready = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("cyc_ready", {63'd0, ready}, {63'd0, m_ready});
      chk("cyc_stall", {63'd0, mul_stall}, {63'd0, m_busy});
      chk("cyc_result", result, m_result);
    end
  end

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                        input logic [63:0] exp, input bit use_exp, input bit toggle,
                        input bit keep_valid, input string name);
    int n;
    @(negedge clk);
    a = ta; b = tbv; sign = ts; valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!ready && n < 60) begin
      if (toggle) begin a = $urandom; b = $urandom; sign = $urandom_range(0, 1); end
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, {63'd0, ready}, 64'd1);
    if (use_exp) chk(name, result, exp);
    if (keep_valid) begin
      @(negedge clk);
      chk({name, "_noreload_stall"}, {63'd0, mul_stall}, 64'd0);
      @(negedge clk);
      chk({name, "_reload_stall"}, {63'd0, mul_stall}, 64'd1);
      n = 0;
      while (!ready && n < 60) begin @(negedge clk); n++; end
      chk({name, "_second_timeout"}, {63'd0, ready}, 64'd1);
    end
    valid = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_result", result, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_stall", {63'd0, mul_stall}, 64'd0);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1, 0, 0, "umax");
    run_op(32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1, 0, 0, "s7xm3");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1, 0, 0, "sm1xm1");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1, 0, 0, "smin_sq");
    run_op(32'd0, 32'h8000_0000, 1'b1, 64'd0, 1, 0, 0, "s0xmin");
    run_op(32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1, 1, 0, "hold");
    run_op(32'hFFFF_FFFF, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, "sm1x2");

    // Abort at iteration 10: result keeps the previous product.
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h0000_0F0F; sign = 1'b0; valid = 1'b1;
    repeat (11) @(negedge clk);
    flush = 1'b1; valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_stall", {63'd0, mul_stall}, 64'd0);
    chk("flush_ready", {63'd0, ready}, 64'd0);
    chk("flush_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    repeat (40) @(negedge clk);
    run_op(32'd3, 32'd5, 1'b0, 64'd15, 1, 0, 0, "after_flush");

    run_op(32'd6, 32'd9, 1'b0, 64'd54, 1, 0, 1, "keep_valid");

    for (int i = 0; i < 20; i++) begin
      logic [31:0] ra, rb;
      logic        rs;
      ra = pick(); rb = pick(); rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, prod(ra, rb, rs), 1, 0, 0, "random");
    end

    // Reset mid-operation clears everything.
    @(negedge clk);
    a = 32'd100; b = 32'd200; sign = 1'b0; valid = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_result", result, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_stall", {63'd0, mul_stall}, 64'd0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
